// File: rtl/muldiv_unit_if.sv
// Request/result bundle between the pipeline and the HI/LO multiply-divide unit.
// The pipeline drives the request side; the unit drives status and the HI/LO view.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic [2:0]       op_i;
  logic [WIDTH-1:0] param_1_i;
  logic [WIDTH-1:0] param_2_i;
  logic             flush_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport master (
    output start_i, op_i, param_1_i, param_2_i, flush_i,
    input  busy_o, done_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, op_i, param_1_i, param_2_i, flush_i,
    output busy_o, done_o, hi_o, lo_o
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU plus MTHI/MTLO into HI/LO; WIDTH+1 cycles per iterative op,
// MTHI/MTLO in one edge. No backpressure: starts while busy are dropped, the pipeline stalls on busy_o.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input logic          clock_i,
  input logic          reset_n_i,
  muldiv_unit_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [5:0] LAST_STEP = 6'(WIDTH - 1);

  logic [1:0]         state_q, state_d;
  logic [5:0]         cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [1:0]         op_q, op_d;
  logic               neg_q, neg_d;
  logic               dneg_q, dneg_d;
  logic               div0_q, div0_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               sgn_in;
  logic [WIDTH-1:0]   mag_a, mag_b, addend, quo, rem;
  logic [WIDTH:0]     sum, rem_sh, diff;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    // op 0 and 2 are the signed variants
    sgn_in = ~bus.op_i[0];
    mag_a  = (sgn_in && bus.param_1_i[WIDTH-1]) ? -bus.param_1_i : bus.param_1_i;
    mag_b  = (sgn_in && bus.param_2_i[WIDTH-1]) ? -bus.param_2_i : bus.param_2_i;

    addend = acc_q[0] ? b_q : '0;
    sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    rem_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, b_q};

    prod = neg_q ? -acc_q : acc_q;
    quo  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem  = dneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    op_d    = op_q;
    neg_d   = neg_q;
    dneg_d  = dneg_q;
    div0_d  = div0_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          if (!bus.op_i[2]) begin
            // multiply and divide both start with the rs magnitude in the low half
            acc_d   = {{WIDTH{1'b0}}, mag_a};
            a_d     = bus.param_1_i;
            b_d     = mag_b;
            op_d    = bus.op_i[1:0];
            neg_d   = sgn_in & (bus.param_1_i[WIDTH-1] ^ bus.param_2_i[WIDTH-1]);
            dneg_d  = sgn_in & bus.param_1_i[WIDTH-1];
            div0_d  = (bus.param_2_i == '0);
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = S_CALC;
          end else if (bus.op_i == 3'd4) begin
            hi_d = bus.param_1_i;
          end else if (bus.op_i == 3'd5) begin
            lo_d = bus.param_1_i;
          end
        end
      end
      S_CALC: begin
        if (!op_q[1]) begin
          acc_d = {sum, acc_q[WIDTH-1:1]};
        end else if (diff[WIDTH]) begin
          acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
          acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == LAST_STEP) state_d = S_FIX;
      end
      S_FIX: begin
        if (!op_q[1]) begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end else if (div0_q) begin
          hi_d = a_q;
          lo_d = '1;
        end else begin
          hi_d = rem;
          lo_d = quo;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // flush wins over everything, including a same-cycle MTHI/MTLO
    if (bus.flush_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      dneg_q  <= 1'b0;
      div0_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      dneg_q  <= dneg_d;
      div0_q  <= div0_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy_o = busy_q;
  assign bus.done_o = done_q;
  assign bus.hi_o   = hi_q;
  assign bus.lo_o   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomized checks of muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(W)) bus ();
  muldiv_unit #(.WIDTH(W)) dut (
    .clock_i  (clk),
    .reset_n_i(rst_n),
    .bus      (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {HI, LO} that the architecture defines for an iterative op
  function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    longint sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    r  = '0;
    case (op)
      3'd0: r = sa * sb;
      3'd1: r = {32'd0, a} * {32'd0, b};
      3'd2: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
        else r = {32'(sa % sb), 32'(sa / sb)};
      end
      3'd3: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else r = {a % b, a / b};
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic idle_inputs();
    bus.start_i   = 1'b0;
    bus.flush_i   = 1'b0;
    bus.op_i      = 3'd0;
    bus.param_1_i = '0;
    bus.param_2_i = '0;
  endtask

  task automatic count_dones(input int n, output int dones);
    dones = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.done_o) dones++;
    end
  endtask

  // Entered at a negedge with the unit idle; leaves at a negedge with the unit idle.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp);
    int cyc;
    bus.start_i   = 1'b1;
    bus.op_i      = op;
    bus.param_1_i = a;
    bus.param_2_i = b;
    @(negedge clk);
    bus.start_i   = 1'b0;
    bus.param_1_i = $urandom;
    bus.param_2_i = $urandom;
    chk({tag, " busy"}, 64'(bus.busy_o), 64'd1);
    cyc = 0;
    while (!bus.done_o && cyc < 100) begin
      if (cyc == 10) chk({tag, " hold"}, {bus.hi_o, bus.lo_o}, {m_hi, m_lo});
      @(negedge clk);
      cyc++;
    end
    chk({tag, " latency"}, 64'(cyc), 64'(W + 1));
    chk({tag, " busy_at_done"}, 64'(bus.busy_o), 64'd0);
    {m_hi, m_lo} = exp;
    chk({tag, " result"}, {bus.hi_o, bus.lo_o}, {m_hi, m_lo});
    @(negedge clk);
    chk({tag, " done_pulse"}, 64'(bus.done_o), 64'd0);
  endtask

  initial begin
    int dones;
    logic [2:0] op;
    logic [31:0] a, b;

    idle_inputs();
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("reset busy", 64'(bus.busy_o), 64'd0);
    chk("reset done", 64'(bus.done_o), 64'd0);
    chk("reset hilo", {bus.hi_o, bus.lo_o}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("mult_neg2x3", 3'd0, 32'hFFFF_FFFE, 32'd3, {32'hFFFF_FFFF, 32'hFFFF_FFFA});
    run_op("multu_neg2x3", 3'd1, 32'hFFFF_FFFE, 32'd3, {32'h0000_0002, 32'hFFFF_FFFA});
    run_op("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op("divu_7_2", 3'd3, 32'd7, 32'd2, {32'd1, 32'd3});
    run_op("divu_5_0", 3'd3, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF});
    run_op("div_m8_0", 3'd2, 32'hFFFF_FFF8, 32'd0, {32'hFFFF_FFF8, 32'hFFFF_FFFF});
    run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000});

    // MTHI then MTLO on back-to-back idle cycles
    bus.start_i = 1'b1; bus.op_i = 3'd4; bus.param_1_i = 32'h1234;
    @(negedge clk);
    m_hi = 32'h1234;
    chk("mthi", {bus.hi_o, bus.lo_o}, {m_hi, m_lo});
    chk("mthi busy", 64'(bus.busy_o), 64'd0);
    bus.op_i = 3'd5; bus.param_1_i = 32'h5678;
    @(negedge clk);
    m_lo = 32'h5678;
    bus.start_i = 1'b0;
    chk("mtlo", {bus.hi_o, bus.lo_o}, {m_hi, m_lo});
    chk("mtlo busy", 64'(bus.busy_o), 64'd0);
    chk("mtlo done", 64'(bus.done_o), 64'd0);

    // second start while busy must be dropped
    bus.start_i = 1'b1; bus.op_i = 3'd0; bus.param_1_i = 32'd7; bus.param_2_i = 32'd6;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (4) @(negedge clk);
    bus.start_i = 1'b1; bus.op_i = 3'd1; bus.param_1_i = 32'd100; bus.param_2_i = 32'd100;
    @(negedge clk);
    bus.start_i = 1'b0;
    count_dones(80, dones);
    m_hi = 32'd0; m_lo = 32'd42;
    chk("restart dones", 64'(dones), 64'd1);
    chk("restart result", {bus.hi_o, bus.lo_o}, {m_hi, m_lo});

    // flush mid-DIV
    bus.start_i = 1'b1; bus.op_i = 3'd2; bus.param_1_i = 32'd1000; bus.param_2_i = 32'd7;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (9) @(negedge clk);
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.flush_i = 1'b0;
    chk("flush busy", 64'(bus.busy_o), 64'd0);
    count_dones(45, dones);
    chk("flush dones", 64'(dones), 64'd0);
    chk("flush hilo", {bus.hi_o, bus.lo_o}, {m_hi, m_lo});

    // flush beats a same-cycle MTHI
    bus.flush_i = 1'b1; bus.start_i = 1'b1; bus.op_i = 3'd4; bus.param_1_i = 32'hDEAD_BEEF;
    @(negedge clk);
    idle_inputs();
    chk("flush_vs_mthi", {bus.hi_o, bus.lo_o}, {m_hi, m_lo});

    // asynchronous reset mid-MULT
    bus.start_i = 1'b1; bus.op_i = 3'd0; bus.param_1_i = 32'd123; bus.param_2_i = 32'd456;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    m_hi = '0; m_lo = '0;
    chk("midreset busy", 64'(bus.busy_o), 64'd0);
    chk("midreset hilo", {bus.hi_o, bus.lo_o}, {m_hi, m_lo});
    @(negedge clk);
    rst_n = 1'b1;
    count_dones(45, dones);
    chk("midreset dones", 64'(dones), 64'd0);
    chk("midreset after", {bus.hi_o, bus.lo_o}, {m_hi, m_lo});

    // randomized mix of every opcode, biased toward corner operands
    for (int i = 0; i < 30; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = 32'($urandom_range(0, 50)); b = 32'($urandom_range(1, 9)); end
        3: b = 32'hFFFF_FFFF;
        default: ;
      endcase
      if (op <= 3'd3) begin
        run_op($sformatf("rand%0d_op%0d", i, op), op, a, b, ref_md(op, a, b));
      end else begin
        bus.start_i = 1'b1; bus.op_i = op; bus.param_1_i = a; bus.param_2_i = b;
        @(negedge clk);
        idle_inputs();
        if (op == 3'd4) m_hi = a;
        if (op == 3'd5) m_lo = a;
        chk($sformatf("rand%0d_op%0d hilo", i, op), {bus.hi_o, bus.lo_o}, {m_hi, m_lo});
        chk($sformatf("rand%0d_op%0d busy", i, op), 64'(bus.busy_o), 64'd0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
